inv_bist_sequencer: RTL and testbench
=====================================

# inv_bist_sequencer

Built-in self-test sequencer for the 8-bit inverting datapath behind the TinyTapeout user pins. On `start` it drives a deterministic stimulus sequence onto the datapath input and waits a fixed latency per vector. It compares each response against the bitwise inverse of the stimulus, counting mismatches and capturing the first failing vector. It sits between the top-level pin wrapper and the datapath, and owns the datapath input whenever `busy` is high.

## Interface
- `NUM_VECTORS`, default 256: vectors per run, range 1..256.
- `LATENCY`, default 1: datapath latency in cycles, range 0..7.
- `ERR_W`, default 8: width of the error counter.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: single-cycle run request; honoured only in IDLE or DONE.
- `abort` in 1: cancels a run in progress.
- `mode` in 1: stimulus source, 0 = counting, 1 = LFSR; sampled on an accepted `start`.
- `dp_stim` out 8: drive to the datapath input.
- `dp_resp` in 8: datapath output.
- `busy` out 1: high while a run is in progress.
- `done` out 1: level; run completed.
- `pass` out 1: `done` and zero errors.
- `err_count` out ERR_W: mismatch count, saturating.
- `fail_valid` out 1: a first failure has been captured.
- `fail_vec` out 8: stimulus value of the first mismatch.

## Operation
- FSM states: IDLE, APPLY, CHECK, DONE.
- IDLE or DONE + `start` -> APPLY. The accepted start:
  - clears `err_count`, `fail_valid`, `fail_vec`, `done`;
  - resets the vector index to 0;
  - loads the stimulus generator and latches `mode`.
- APPLY holds `dp_stim` for LATENCY cycles (wait counter), then -> CHECK. With LATENCY=0, APPLY is skipped and the FSM goes straight to CHECK.
- CHECK compares `dp_resp` with `~dp_stim`.
  - On mismatch, `err_count` increments and saturates at 2^ERR_W-1.
  - If `fail_valid`=0, capture `fail_vec`=`dp_stim` and set `fail_valid`.
  - If index = NUM_VECTORS-1 -> DONE; otherwise advance the generator and index -> APPLY.
- DONE holds all results until the next accepted `start`.
- Counting mode: vector k = k[7:0].
- LFSR mode: seed 0x01, next = {cur[6:0], cur[7]^cur[5]^cur[4]^cur[3]}. Period 255, so vector 255 repeats the seed.
- `abort` in APPLY or CHECK -> IDLE. Results are frozen at their current values, `done` stays 0. `abort` is ignored in IDLE and DONE.
- `start` while `busy` is ignored. `start` and `abort` together: `abort` wins when `busy`, `start` wins otherwise.
- In IDLE and DONE, `dp_stim` holds its last driven value.

## Timing
- All outputs are registered. Reset value of every output is 0, including `dp_stim`.
- Reset mid-run returns to IDLE immediately, with all outputs 0.
- Start accepted at edge t:
  - `busy`=1 and vector 0 on `dp_stim` from t+1.
  - Each vector occupies LATENCY+1 cycles.
  - The compare happens in the last cycle of the vector.
- Run length is NUM_VECTORS*(LATENCY+1) cycles. `busy` falls and `done` rises on the same edge after the final CHECK.
- A result update from CHECK is visible on the following cycle.
- `pass` = `done` & (`err_count`==0), registered together with `done`.

## Structure
- Package `inv_bist_pkg` holds:
  - the state enum;
  - the LFSR seed (0x01) and tap mask (0xB8: bits 7,5,4,3);
  - the mode encodings.
- Sub-module `lfsr8` (load, advance, value). The counting path and the FSM stay in the top module.

## Test plan
- Ideal inverter model, LATENCY=1, mode 0, `start` -> `done` 512 cycles after start; `err_count`=0, `pass`=1, `fail_valid`=0.
- Model with output bit0 stuck at 0, mode 0 -> `err_count`=128, `fail_vec`=0x00, `pass`=0.
- Same stuck model with ERR_W=4 -> `err_count` saturates at 15; `fail_vec`=0x00.
- Mode 1 with an ideal model -> first `dp_stim` values 0x01, 0x02, 0x04, 0x08, 0x11, each held 2 cycles; `pass`=1.
- `abort` at vector 10 -> IDLE next cycle; `busy`=0, `done`=0. A second `start` while `busy` is ignored. A fresh `start` then runs a full 512-cycle pass.
- `rst` asserted mid-run -> all outputs 0 asynchronously. After `rst` deasserts, `start` behaves as from power-up.

Source files
------------

// File: rtl/inv_bist_pkg.sv
// Shared types and constants for the inverting-datapath BIST sequencer.
package inv_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam logic MODE_COUNT = 1'b0;
    localparam logic MODE_LFSR  = 1'b1;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/inv_bist_sequencer_lfsr8.sv
// 8-bit Fibonacci LFSR stimulus source; holds the vector one step ahead of dp_stim.
module lfsr8
    import inv_bist_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] value
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    // Load primes with the seed's successor, since the seed itself goes straight to dp_stim.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = lfsr_next(LFSR_SEED);
        end else if (advance) begin
            value_d = lfsr_next(value_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= LFSR_SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/inv_bist_sequencer.sv
// BIST sequencer: drives counting/LFSR vectors into an inverting datapath and checks responses.
module inv_bist_sequencer
    import inv_bist_pkg::*;
#(
    parameter int unsigned NUM_VECTORS = 256,
    parameter int unsigned LATENCY     = 1,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    output logic [7:0]       dp_stim,
    input  logic [7:0]       dp_resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [7:0]       fail_vec
);

    localparam int unsigned WAIT_W    = 3;
    localparam logic [7:0]  LAST_IDX  = 8'(NUM_VECTORS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((LATENCY == 0) ? 0 : LATENCY - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};
    localparam state_e VEC_ST = (LATENCY == 0) ? ST_CHECK : ST_APPLY;

    state_e            state_q, state_d;
    logic [7:0]        idx_q, idx_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              mode_q, mode_d;
    logic [7:0]        dp_stim_q, dp_stim_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              fail_valid_q, fail_valid_d;
    logic [7:0]        fail_vec_q, fail_vec_d;

    logic              lfsr_load;
    logic              lfsr_adv;
    logic [7:0]        lfsr_value;

    lfsr8 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .value   (lfsr_value)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wait_d       = wait_q;
        mode_d       = mode_q;
        dp_stim_d    = dp_stim_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        lfsr_load    = 1'b0;
        lfsr_adv     = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = VEC_ST;
                    idx_d        = 8'd0;
                    wait_d       = '0;
                    mode_d       = mode;
                    dp_stim_d    = (mode == MODE_LFSR) ? LFSR_SEED : 8'h00;
                    lfsr_load    = 1'b1;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_d        = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = 8'h00;
                end
            end

            ST_APPLY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_CHECK: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (dp_resp != ~dp_stim_q) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            fail_vec_d   = dp_stim_q;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d   = VEC_ST;
                        idx_d     = idx_q + 8'd1;
                        wait_d    = '0;
                        lfsr_adv  = 1'b1;
                        dp_stim_d = (mode_q == MODE_LFSR) ? lfsr_value : idx_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 8'd0;
            wait_q       <= '0;
            mode_q       <= MODE_COUNT;
            dp_stim_q    <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            mode_q       <= mode_d;
            dp_stim_q    <= dp_stim_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    assign dp_stim    = dp_stim_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_inv_bist_sequencer.sv
// Scoreboard bench: two sequencers (ERR_W 8 and 4) against registered inverter models.
module tb_inv_bist_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, abort, mode, stuck;
    logic [7:0] dp_stim, dp_resp, dp_stim4, dp_resp4;
    logic       busy, done, pass, fail_valid;
    logic [7:0] err_count, fail_vec;
    logic       busy4, done4, pass4, fail_valid4;
    logic [3:0] err_count4;
    logic [7:0] fail_vec4;

    always #5 clk = ~clk;

    inv_bist_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .dp_stim(dp_stim), .dp_resp(dp_resp), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid), .fail_vec(fail_vec)
    );

    inv_bist_sequencer #(.ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .dp_stim(dp_stim4), .dp_resp(dp_resp4), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err_count4), .fail_valid(fail_valid4), .fail_vec(fail_vec4)
    );

    // One-cycle inverting datapath; 'stuck' forces output bit0 to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_resp  <= 8'h00;
            dp_resp4 <= 8'h00;
        end else begin
            dp_resp  <= ~dp_stim  & (stuck ? 8'hFE : 8'hFF);
            dp_resp4 <= ~dp_stim4 & (stuck ? 8'hFE : 8'hFF);
        end
    end

    typedef struct {
        int         cycles;
        logic       done;
        logic       pass;
        logic [7:0] err;
        logic       fv;
        logic [7:0] fvec;
        logic [3:0] err4;
        logic [7:0] stim;
        int         start_cyc;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] stimq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    logic       busy_prev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic exp_t mk(input int cycles, input logic dn, input logic ps,
                                input logic [7:0] err, input logic fv, input logic [7:0] fvec,
                                input logic [3:0] err4, input logic [7:0] stim);
        exp_t e;
        e.cycles = cycles; e.done = dn; e.pass = ps; e.err = err; e.fv = fv;
        e.fvec = fvec; e.err4 = err4; e.stim = stim; e.start_cyc = 0;
        return e;
    endfunction

    // Monitor: per-cycle stimulus checks while busy, full result check when busy falls.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && stimq.size() > 0) begin : stim_pop
                logic [7:0] es;
                es = stimq.pop_front();
                chk("dp_stim_seq", 32'(dp_stim), 32'(es));
            end
            if (busy_prev && !busy) begin : run_end
                exp_t ex;
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL run_end: unexpected end of run at cycle %0d", cyc);
                end else begin
                    ex = expq.pop_front();
                    chk("run_cycles", 32'(cyc - ex.start_cyc), 32'(ex.cycles));
                    chk("done",       32'(done),       32'(ex.done));
                    chk("pass",       32'(pass),       32'(ex.pass));
                    chk("err_count",  32'(err_count),  32'(ex.err));
                    chk("fail_valid", 32'(fail_valid), 32'(ex.fv));
                    chk("fail_vec",   32'(fail_vec),   32'(ex.fvec));
                    chk("final_stim", 32'(dp_stim),    32'(ex.stim));
                    chk("err4_sat",   32'(err_count4), 32'(ex.err4));
                    chk("fail_vec4",  32'(fail_vec4),  32'(ex.fvec));
                    chk("busy4",      32'(busy4),      32'(0));
                end
            end
        end
        busy_prev = busy;
    end

    task automatic launch(input logic m, input logic stk, input logic push, input exp_t ex);
        stuck = stk;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        ex.start_cyc = cyc;
        if (push) expq.push_back(ex);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (expq.size() > 0 || stimq.size() > 0); i++) @(negedge clk);
        if (expq.size() > 0 || stimq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d results, %0d stimuli still pending", expq.size(), stimq.size());
            expq.delete();
            stimq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},   32'(busy),       32'(0));
        chk({tag, "_done"},   32'(done),       32'(0));
        chk({tag, "_pass"},   32'(pass),       32'(0));
        chk({tag, "_err"},    32'(err_count),  32'(0));
        chk({tag, "_fv"},     32'(fail_valid), 32'(0));
        chk({tag, "_fvec"},   32'(fail_vec),   32'(0));
        chk({tag, "_stim"},   32'(dp_stim),    32'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; stuck = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Ideal counting run
        stimq = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02};
        launch(1'b0, 1'b0, 1'b1, mk(512, 1'b1, 1'b1, 8'd0, 1'b0, 8'h00, 4'd0, 8'hFF));
        drain();

        // Bit0 stuck at 0: every even vector mismatches
        launch(1'b0, 1'b1, 1'b1, mk(512, 1'b1, 1'b0, 8'd128, 1'b1, 8'h00, 4'd15, 8'hFF));
        drain();

        // Ideal LFSR run; vector 255 wraps back to the seed
        stimq = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h04, 8'h04, 8'h08, 8'h08, 8'h11, 8'h11};
        launch(1'b1, 1'b0, 1'b1, mk(512, 1'b1, 1'b1, 8'd0, 1'b0, 8'h00, 4'd0, 8'h01));
        drain();

        // Start while busy is ignored; abort during vector 10
        launch(1'b0, 1'b0, 1'b1, mk(21, 1'b0, 1'b0, 8'd0, 1'b0, 8'h00, 4'd0, 8'h0A));
        repeat (9) @(negedge clk);
        start = 1'b1;
        mode  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = 1'b0;
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        drain();

        // Fresh start after abort
        launch(1'b0, 1'b0, 1'b1, mk(512, 1'b1, 1'b1, 8'd0, 1'b0, 8'h00, 4'd0, 8'hFF));
        drain();

        // Asynchronous reset mid-run with errors already accumulated
        launch(1'b0, 1'b1, 1'b0, mk(0, 1'b0, 1'b0, 8'd0, 1'b0, 8'h00, 4'd0, 8'h00));
        repeat (100) @(negedge clk);
        chk("pre_reset_err_nonzero", 32'(err_count != 8'd0), 32'(1));
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stuck = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("post_rst");

        // Run after reset behaves as from power-up
        stimq = '{8'h00, 8'h00, 8'h01, 8'h01};
        launch(1'b0, 1'b0, 1'b1, mk(512, 1'b1, 1'b1, 8'd0, 1'b0, 8'h00, 4'd0, 8'hFF));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
